// File: rtl/add_pipe_if.sv
// Valid/ready bus for the segmented pipelined adder: operand beat in, result beat out.
interface add_pipe_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/add_pipe.sv
// WIDTH-bit add/subtract split into SEGS carry-linked segments, one register stage each,
// with a collapsing valid/ready pipeline (full throughput, lossless backpressure).
module add_pipe #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    add_pipe_if.slave  bus
);
    if (SEGS < 1 || SEGS > WIDTH || WIDTH < 2) begin : g_bad_params
        $error("add_pipe: need WIDTH >= 2 and 1 <= SEGS <= WIDTH");
    end else if (WIDTH % SEGS != 0) begin : g_bad_split
        $error("add_pipe: SEGS must divide WIDTH exactly");
    end

    localparam int SW = (SEGS >= 1) ? WIDTH / SEGS : 1;

    // Stage k sees only operand bits not yet consumed, so its slice is always at [SW-1:0].
    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        localparam int RI = WIDTH - k * SW;
        localparam int SO = (k + 1) * SW;

        logic [RI-1:0] a_i;
        logic [RI-1:0] b_i;
        logic          c_i;
        logic          v_i;
        logic [SW:0]   seg;
        logic [SO-1:0] s_n;
        logic          rdy;
        logic          rdy_nx;
        logic          v_q;
        logic          c_q;
        logic [SO-1:0] s_q;

        if (k == 0) begin : g_head
            assign a_i = bus.in_a;
            assign b_i = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign c_i = bus.in_sub ^ bus.in_cin;
            assign v_i = bus.in_valid;
            assign s_n = seg[SW-1:0];
        end else begin : g_tail
            assign a_i = g_stage[k-1].g_fwd.a_q;
            assign b_i = g_stage[k-1].g_fwd.b_q;
            assign c_i = g_stage[k-1].c_q;
            assign v_i = g_stage[k-1].v_q;
            assign s_n = {seg[SW-1:0], g_stage[k-1].s_q};
        end

        assign seg = {1'b0, a_i[SW-1:0]} + {1'b0, b_i[SW-1:0]} + {{SW{1'b0}}, c_i};
        // An empty stage always accepts, so bubbles collapse under a stalled output.
        assign rdy = !v_q || rdy_nx;

        // NOTE: sequential state uses non-blocking assignments so every stage samples
        // its predecessor's pre-edge value; blocking here would smear a beat across stages.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (rdy) begin
                v_q <= v_i;
                if (v_i) begin
                    c_q <= seg[SW];
                    s_q <= s_n;
                end
            end
        end

        if (k < SEGS - 1) begin : g_fwd
            logic [RI-SW-1:0] a_q;
            logic [RI-SW-1:0] b_q;

            assign rdy_nx = g_stage[k+1].rdy;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (rdy && v_i) begin
                    a_q <= a_i[RI-1:SW];
                    b_q <= b_i[RI-1:SW];
                end
            end
        end else begin : g_last
            logic ovf_q;

            assign rdy_nx = bus.out_ready;

            // The last slice's top bits are the operand sign bits.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (rdy && v_i) begin
                    ovf_q <= (a_i[SW-1] == b_i[SW-1]) && (seg[SW-1] != a_i[SW-1]);
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].rdy;
    assign bus.out_valid = g_stage[SEGS-1].v_q;
    assign bus.out_sum   = g_stage[SEGS-1].s_q;
    assign bus.out_cout  = g_stage[SEGS-1].c_q;
    assign bus.out_ovf   = g_stage[SEGS-1].g_last.ovf_q;
endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: 32/4 pipeline under streaming, backpressure and reset,
// plus single-beat latency and value checks of 48/3 and 8/1 builds.
module tb_add_pipe;
    localparam int SEGS = 4;

    typedef struct {
        logic [47:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   occ      = 0;
    bit   strict_lat = 1'b0;
    bit   mon_on     = 1'b0;
    exp_t sb[$];

    add_pipe_if #(.WIDTH(32)) bus();
    add_pipe_if #(.WIDTH(48)) b48();
    add_pipe_if #(.WIDTH(8))  b8();

    add_pipe #(.WIDTH(32), .SEGS(4)) dut   (.clk(clk), .rst(rst), .bus(bus));
    add_pipe #(.WIDTH(48), .SEGS(3)) dut48 (.clk(clk), .rst(rst), .bus(b48));
    add_pipe #(.WIDTH(8),  .SEGS(1)) dut8  (.clk(clk), .rst(rst), .bus(b8));

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arithmetic straight from the add/sub definition, for any width up to 48.
    function automatic exp_t model(input int w, input logic [47:0] a, input logic [47:0] b,
                                   input logic cin, input logic sub);
        logic [48:0] mask;
        logic [48:0] full;
        logic [47:0] am;
        logic [47:0] bm;
        exp_t        e;
        mask   = (49'd1 << w) - 49'd1;
        am     = a & mask[47:0];
        bm     = (sub ? ~b : b) & mask[47:0];
        full   = {1'b0, am} + {1'b0, bm} + {48'd0, sub ^ cin};
        e.sum  = full[47:0] & mask[47:0];
        e.cout = full[w];
        e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
        e.cyc  = 0;
        return e;
    endfunction

    // Output monitor for the 32-bit pipe; all sampling happens on the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] ps;
        logic        pc;
        logic        po;
        bit          pstall;
        logic        exp_rdy;
        int          lat;
        pstall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                occ    = 0;
                pstall = 1'b0;
            end else if (mon_on) begin
                if (pstall) begin
                    n_assert++;
                    if (bus.out_valid !== 1'b1 || bus.out_sum !== ps || bus.out_cout !== pc ||
                        bus.out_ovf !== po) begin
                        n_fail++;
                        $display("FAIL hold: valid=%b sum=%h cout=%b ovf=%b, required held sum=%h cout=%b ovf=%b",
                                 bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, ps, pc, po);
                    end
                end
                exp_rdy = !(occ == SEGS && !bus.out_ready);
                n_assert++;
                if (bus.in_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL in_ready: got %b, required %b (occupancy %0d, out_ready %b)",
                             bus.in_ready, exp_rdy, occ, bus.out_ready);
                end
                n_assert++;
                if (bus.out_valid === 1'b1 && occ == 0) begin
                    n_fail++;
                    $display("FAIL stale: out_valid=1 with sum=%h while no beat is in flight", bus.out_sum);
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    n_assert++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_out: sum=%h with empty scoreboard", bus.out_sum);
                    end else begin
                        e   = sb.pop_front();
                        lat = cyc - e.cyc;
                        if (bus.out_sum !== e.sum[31:0] || bus.out_cout !== e.cout ||
                            bus.out_ovf !== e.ovf || (strict_lat ? lat != SEGS : lat < SEGS)) begin
                            n_fail++;
                            $display("FAIL result: got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                                     bus.out_sum, bus.out_cout, bus.out_ovf, lat,
                                     e.sum[31:0], e.cout, e.ovf, SEGS);
                        end
                    end
                    if (occ > 0) occ--;
                end
                if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) occ++;
                pstall = bus.out_valid && !bus.out_ready;
                ps     = bus.out_sum;
                pc     = bus.out_cout;
                po     = bus.out_ovf;
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input exp_t e);
        bit ok;
        int t;
        ok = 1'b0;
        t  = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) begin
                e.cyc = cyc;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: beat a=%h b=%h not taken in %0d cycles", a, b, t);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        drive(a, b, cin, sub, model(32, {16'd0, a}, {16'd0, b}, cin, sub));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        bus.out_ready = 1'b1;
        b48.in_valid = 1'b0; b48.in_a = '0; b48.in_b = '0; b48.in_cin = 1'b0; b48.in_sub = 1'b0;
        b48.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in_a = '0; b8.in_b = '0; b8.in_cin = 1'b0; b8.in_sub = 1'b0;
        b8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_assert++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b sum=%h cout=%b ovf=%b, required all 0",
                     bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_assert++;
        if (bus.in_ready !== 1'b1 || b48.in_ready !== 1'b1 || b8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready 32/48/8 = %b/%b/%b, required 1/1/1",
                     bus.in_ready, b48.in_ready, b8.in_ready);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_directed();
        strict_lat    = 1'b1;
        bus.out_ready = 1'b1;
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, exp_t'{48'h0000_0000, 1'b1, 1'b0, 0});
        drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, exp_t'{48'h8000_0000, 1'b0, 1'b1, 0});
        drive(32'h5,         32'h7, 1'b0, 1'b1, exp_t'{48'hFFFF_FFFE, 1'b0, 1'b0, 0});
        drive(32'hA,         32'h3, 1'b1, 1'b1, exp_t'{48'h0000_0006, 1'b1, 1'b0, 0});
        drive(32'h0000_00FF, 32'h0, 1'b1, 1'b0, exp_t'{48'h0000_0100, 1'b0, 1'b0, 0});
        drive(32'h8000_0000, 32'h1, 1'b0, 1'b1, exp_t'{48'h7FFF_FFFF, 1'b1, 1'b1, 0});
        wait_empty();
    endtask

    task automatic test_stream();
        int c0;
        strict_lat    = 1'b1;
        bus.out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        n_assert++;
        if (cyc - c0 != 100) begin
            n_fail++;
            $display("FAIL stream_rate: 100 beats took %0d cycles, required 100", cyc - c0);
        end
        wait_empty();
    endtask

    task automatic test_back_to_back_full();
        strict_lat    = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < SEGS; i++) send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        fork
            send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_empty();
    endtask

    task automatic test_backpressure();
        bit done;
        strict_lat = 1'b0;
        done       = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    idle($urandom_range(0, 2));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_empty();
    endtask

    task automatic test_reset_flight();
        strict_lat    = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'hF0F0_0000 + i, 32'h0F0F_1234, 1'b0, 1'b0);
        idle(3);
        n_assert++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_setup: out_valid=%b before reset, required 1", bus.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_assert++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL flight_reset: valid=%b sum=%h cout=%b ovf=%b, required all 0",
                     bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
        end
        sb.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        strict_lat = 1'b1;
        send(32'h0000_0042, 32'h0000_0001, 1'b0, 1'b0);
        wait_empty();
        idle(6);
    endtask

    task automatic one_shot48(input logic [47:0] a, input logic [47:0] b, input logic cin, input logic sub);
        exp_t e;
        int   t;
        e = model(48, a, b, cin, sub);
        t = 0;
        b48.in_valid = 1'b1; b48.in_a = a; b48.in_b = b; b48.in_cin = cin; b48.in_sub = sub;
        do begin
            @(posedge clk);
            t++;
            #1;
            b48.in_valid = 1'b0;
        end while (b48.out_valid !== 1'b1 && t < 20);
        n_assert++;
        if (t != 3 || b48.out_sum !== e.sum || b48.out_cout !== e.cout || b48.out_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL w48: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=3",
                     a, b, cin, sub, b48.out_sum, b48.out_cout, b48.out_ovf, t, e.sum, e.cout, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one_shot8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        exp_t e;
        int   t;
        e = model(8, {40'd0, a}, {40'd0, b}, cin, sub);
        t = 0;
        b8.in_valid = 1'b1; b8.in_a = a; b8.in_b = b; b8.in_cin = cin; b8.in_sub = sub;
        do begin
            @(posedge clk);
            t++;
            #1;
            b8.in_valid = 1'b0;
        end while (b8.out_valid !== 1'b1 && t < 20);
        n_assert++;
        if (t != 1 || b8.out_sum !== e.sum[7:0] || b8.out_cout !== e.cout || b8.out_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL w8: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=1",
                     a, b, cin, sub, b8.out_sum, b8.out_cout, b8.out_ovf, t, e.sum[7:0], e.cout, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_widths();
        one_shot48(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0);
        one_shot48(48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0);
        one_shot48(48'h8000_0000_0000, 48'h1, 1'b0, 1'b1);
        one_shot48(48'h5, 48'h7, 1'b0, 1'b1);
        one_shot48(48'h0000_FFFF_FFFF, 48'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            one_shot48({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        one_shot8(8'hFF, 8'h01, 1'b0, 1'b0);
        one_shot8(8'h7F, 8'h01, 1'b0, 1'b0);
        one_shot8(8'h80, 8'h01, 1'b0, 1'b1);
        one_shot8(8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            one_shot8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_back_to_back_full();
        test_backpressure();
        test_reset_flight();
        test_widths();
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expected results never appeared, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
